// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the byte-enabled dual-port RAM.
//   - RDW_READ_FIRST / RDW_WRITE_FIRST : same-address read/write policy codes
//   - init_state_t                     : init sequencer states (CLEAR, IDLE)
//   - even_parity()                    : even parity of one byte lane
//   - be_merge()                       : byte-enable merge of old/new words
// Helpers take maximum-width arguments so one package serves every
// instance; callers zero-extend with size casts.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BYTE_WIDTH = 64;
    localparam int MAX_NBYTES     = 32;

    typedef enum logic {CLEAR, IDLE} init_state_t;

    // Zero-extension does not change parity, so a narrow lane can be passed
    // in zero-extended.
    function automatic logic even_parity(input logic [MAX_BYTE_WIDTH-1:0] slice);
        return ^slice;
    endfunction

    // Bits in lanes with be set come from new_word, all others from old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_NBYTES-1:0]     be,
        input int                        byte_width
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        logic [4:0]                lane;
        merged = old_word;
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            lane = 5'(b / byte_width);
            if ((b / byte_width) < MAX_NBYTES && be[lane]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_dp_be_if.sv
// ram_dp_be_if: write port, read port and status of ram_dp_be.
//   master : drives wr_en/wr_addr/wr_be/wr_data and rd_en/rd_addr,
//            observes rd_data/rd_valid/busy/par_err
//   slave  : the RAM side (the reverse directions)
interface ram_dp_be_if #(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NBYTES-1:0]     wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  par_err;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, par_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, par_err
    );
endinterface

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset clear sweep for ram_dp_be.
//   clk, rst  : clock, asynchronous active-high reset
//   busy      : high while the sweep runs (requests are ignored)
//   clr_stb   : write an all-zero word at clr_addr this cycle
//   clr_addr  : sweep address, 0..DEPTH-1
// A reset during the sweep restarts it from address 0.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int DEPTH          = 3072,
    parameter int ADDR_WIDTH     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_stb,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam init_state_t           RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

    init_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    // NOTE: clocked state uses <= so every flop samples pre-edge values;
    // the combinational block below uses = because it models plain wires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_stb   = 1'b0;
        clr_addr  = cnt;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                clr_stb = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port RAM (one write, one read port, one clock)
// with per-byte write enables, read latency 1 or 2, selectable
// read-during-write policy, read-valid strobe and post-reset clear sweep.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ram_dp_be_if.slave (write port, read port, rd_valid, busy,
//              par_err)
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per
// lane and report mismatches on par_err; otherwise par_err is tied to 0.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int DEPTH          = 3072,
    parameter int ADDR_WIDTH     = 12,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic         clk,
    input logic         rst,
    ram_dp_be_if.slave  bus
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  init_busy, clr_stb;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_init_seq #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init (
        .clk      (clk),
        .rst      (rst),
        .busy     (init_busy),
        .clr_stb  (clr_stb),
        .clr_addr (clr_addr)
    );

    logic wr_in_range, rd_in_range, wr_acc, rd_acc, collide;

    // Extra MSB so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_X;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_X;
    assign wr_acc      = bus.wr_en & ~init_busy & wr_in_range;
    assign rd_acc      = bus.rd_en & ~init_busy;
    assign collide     = wr_acc & rd_acc & rd_in_range & (bus.rd_addr == bus.wr_addr);

    // Single physical write port shared by the clear sweep and user writes.
    logic [NBYTES-1:0]     mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = '0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (init_busy) begin
            mem_we    = clr_stb ? '1 : '0;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = bus.wr_be;
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; storage is zeroed by the sweep instead,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we[i]) begin
                mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array-stage read word; the collision policy is resolved here only.
    logic [DATA_WIDTH-1:0] old_word, rd_word;
    logic                  rd_perr;

    always_comb begin
        old_word = rd_in_range ? mem[bus.rd_addr] : '0;
        rd_word  = old_word;
        if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
            rd_word = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(bus.wr_data),
                                           MAX_NBYTES'(bus.wr_be), BYTE_WIDTH));
        end
    end

`ifdef RAM_PARITY_EN
    logic [NBYTES-1:0] par_mem [DEPTH];
    logic [NBYTES-1:0] old_par, eff_par;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we[i]) begin
                par_mem[mem_waddr][i] <= even_parity(MAX_BYTE_WIDTH'(mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH]));
            end
        end
    end

    // Lanes replaced by a write-first merge carry freshly computed parity;
    // untouched lanes are still checked against what was stored.
    always_comb begin
        old_par = rd_in_range ? par_mem[bus.rd_addr] : '0;
        eff_par = old_par;
        if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.wr_be[i]) begin
                    eff_par[i] = even_parity(MAX_BYTE_WIDTH'(bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]));
                end
            end
        end
        rd_perr = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            rd_perr = rd_perr | (even_parity(MAX_BYTE_WIDTH'(rd_word[i*BYTE_WIDTH +: BYTE_WIDTH])) ^ eff_par[i]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    // First output stage: data and error only load on an accepted read so
    // rd_data holds between valid cycles.
    logic                  v1, p1;
    logic [DATA_WIDTH-1:0] d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            p1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                d1 <= rd_word;
                p1 <= rd_perr;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  v2, p2;
            logic [DATA_WIDTH-1:0] d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                    p2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                        p2 <= p1;
                    end
                end
            end

            assign bus.rd_valid = v2;
            assign bus.rd_data  = d2;
            assign bus.par_err  = p2;
        end else begin : g_lat1
            assign bus.rd_valid = v1;
            assign bus.rd_data  = d1;
            assign bus.par_err  = p1;
        end
    endgenerate

    assign bus.busy = init_busy;

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: two instances of ram_dp_be checked cycle by cycle against a
// behavioural model (word array, pending-read schedule, sweep countdown).
//   dut_a : defaults (DEPTH 3072, latency 1, read-first)
//   dut_b : DEPTH 20, ADDR_WIDTH 5, latency 2, write-first
module tb_ram_dp_be;

    localparam int AW_A    = 12;
    localparam int AW_B    = 5;
    localparam int DEPTH_A = 3072;
    localparam int DEPTH_B = 20;

    typedef struct {
        logic        we;
        int          waddr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        re;
        int          raddr;
    } req_t;

    typedef struct {
        int          dut;
        req_t        req;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_t req_a, req_b;

    ram_dp_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(AW_A)) bus_a ();
    ram_dp_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(AW_B)) bus_b ();

    assign bus_a.wr_en   = req_a.we;
    assign bus_a.wr_addr = AW_A'(req_a.waddr);
    assign bus_a.wr_be   = req_a.be;
    assign bus_a.wr_data = req_a.wdata;
    assign bus_a.rd_en   = req_a.re;
    assign bus_a.rd_addr = AW_A'(req_a.raddr);
    assign bus_b.wr_en   = req_b.we;
    assign bus_b.wr_addr = AW_B'(req_b.waddr);
    assign bus_b.wr_be   = req_b.be;
    assign bus_b.wr_data = req_b.wdata;
    assign bus_b.rd_en   = req_b.re;
    assign bus_b.rd_addr = AW_B'(req_b.raddr);

    ram_dp_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(DEPTH_A), .ADDR_WIDTH(AW_A),
                .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    ram_dp_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(DEPTH_B), .ADDR_WIDTH(AW_B),
                .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // ---------------- reference model ----------------
    logic [15:0] mdl_mem [2][DEPTH_A];
    bit          corrupt [2][DEPTH_A];
    int          sweep_left [2];
    logic        slot_v [2][4];
    logic [15:0] slot_d [2][4];
    logic        slot_p [2][4];
    logic [15:0] last_d [2];
    int          cyc;
    int          total;
    int          bad;

    function automatic int depth_of(input int d); return (d == 0) ? DEPTH_A : DEPTH_B; endfunction
    function automatic int lat_of(input int d);   return (d == 0) ? 1 : 2;             endfunction
    function automatic int rdw_of(input int d);   return (d == 0) ? 0 : 1;             endfunction
    function automatic int aw_of(input int d);    return (d == 0) ? AW_A : AW_B;       endfunction

    function automatic logic        obs_valid(input int d); return (d == 0) ? bus_a.rd_valid : bus_b.rd_valid; endfunction
    function automatic logic [15:0] obs_data(input int d);  return (d == 0) ? bus_a.rd_data  : bus_b.rd_data;  endfunction
    function automatic logic        obs_busy(input int d);  return (d == 0) ? bus_a.busy     : bus_b.busy;     endfunction
    function automatic logic        obs_perr(input int d);  return (d == 0) ? bus_a.par_err  : bus_b.par_err;  endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            sweep_left[d] = depth_of(d);
            last_d[d]     = 16'h0;
            for (int s = 0; s < 4; s++) slot_v[d][s] = 1'b0;
            for (int a = 0; a < DEPTH_A; a++) begin
                mdl_mem[d][a] = 16'h0;
                corrupt[d][a] = 1'b0;
            end
        end
    endtask

    // Effect of one clock edge on the model, given the requests held before it.
    task automatic model_edge(input int d, input req_t r);
        int          dep;
        bit          was_busy;
        int          slot;
        logic [15:0] res;
        logic        pe;
        dep      = depth_of(d);
        was_busy = sweep_left[d] > 0;
        slot     = (cyc + lat_of(d) - 1) % 4;
        if (was_busy) sweep_left[d]--;
        if (!was_busy && r.re) begin
            res = 16'h0;
            pe  = 1'b0;
            if (r.raddr < dep) begin
                res = mdl_mem[d][r.raddr];
                pe  = corrupt[d][r.raddr];
                if (rdw_of(d) == 1 && r.we && r.waddr == r.raddr) begin
                    for (int l = 0; l < 2; l++) if (r.be[l]) res[l*8 +: 8] = r.wdata[l*8 +: 8];
                    if (r.be[0]) pe = 1'b0;
                end
            end
            slot_v[d][slot] = 1'b1;
            slot_d[d][slot] = res;
            slot_p[d][slot] = pe;
        end
        if (!was_busy && r.we && r.waddr < dep) begin
            for (int l = 0; l < 2; l++) if (r.be[l]) mdl_mem[d][r.waddr][l*8 +: 8] = r.wdata[l*8 +: 8];
            if (r.be[0]) corrupt[d][r.waddr] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int d);
        string p;
        int    s;
        logic  ev;
        logic  ep;
        p  = (d == 0) ? "a" : "b";
        s  = cyc % 4;
        ev = slot_v[d][s];
        ep = 1'b0;
        if (ev) begin
            last_d[d]    = slot_d[d][s];
            ep           = slot_p[d][s];
            slot_v[d][s] = 1'b0;
        end
        check({p, "_rd_valid"}, obs_valid(d), ev);
        check({p, "_rd_data"},  obs_data(d),  last_d[d]);
        check({p, "_busy"},     obs_busy(d),  sweep_left[d] > 0);
        if (ev) check({p, "_par_err"}, obs_perr(d), ep);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge(0, req_a);
        model_edge(1, req_b);
        check_outputs(0);
        check_outputs(1);
        cyc++;
    endtask

    task automatic set_idle();
        req_a = '{1'b0, 0, 2'b00, 16'h0, 1'b0, 0};
        req_b = '{1'b0, 0, 2'b00, 16'h0, 1'b0, 0};
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_rd_valid", obs_valid(d), 1'b0);
            check("rst_rd_data",  obs_data(d),  16'h0);
            check("rst_par_err",  obs_perr(d),  1'b0);
            check("rst_busy",     obs_busy(d),  1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs both sweeps to completion, issuing requests that must be ignored.
    task automatic sweep_both();
        int n_a;
        int n_b;
        n_a = obs_busy(0) ? 1 : 0;
        n_b = obs_busy(1) ? 1 : 0;
        for (int i = 0; i < DEPTH_A + 8; i++) begin
            if (!obs_busy(0) && !obs_busy(1)) break;
            set_idle();
            if (i == 10) req_a = '{1'b1, 11, 2'b11, 16'hBEEF, 1'b1, 11};
            if (i == 11) req_a = '{1'b0, 0, 2'b00, 16'h0, 1'b1, 0};
            if (i == 5)  req_b = '{1'b1, 11, 2'b11, 16'hBEEF, 1'b1, 11};
            if (i == 6)  req_b = '{1'b0, 0, 2'b00, 16'h0, 1'b1, 3};
            step();
            if (obs_busy(0)) n_a++;
            if (obs_busy(1)) n_b++;
        end
        set_idle();
        check("a_busy_len", n_a, DEPTH_A);
        check("b_busy_len", n_b, DEPTH_B);
    endtask

    function automatic req_t rand_req(input int d);
        req_t r;
        int   dep;
        int   span;
        dep     = depth_of(d);
        span    = (1 << aw_of(d)) - dep;
        r.we    = 1'($urandom_range(0, 1));
        r.waddr = ($urandom_range(0, 15) == 0) ? dep + int'($urandom_range(0, span - 1)) : int'($urandom_range(0, 15));
        r.be    = 2'($urandom_range(0, 3));
        r.wdata = 16'($urandom);
        r.re    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) r.raddr = r.waddr;
        else r.raddr = ($urandom_range(0, 15) == 0) ? dep + int'($urandom_range(0, span - 1)) : int'($urandom_range(0, 15));
        return r;
    endfunction

    vec_t vecs[$];

    function automatic void add(input int d, input logic we, input int wa, input logic [1:0] be,
                                input logic [15:0] wd, input logic re, input int ra,
                                input logic chk, input logic [15:0] exp);
        vec_t v;
        v.dut = d;
        v.req = '{we, wa, be, wd, re, ra};
        v.chk = chk;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        cyc   = 0;

        for (int d = 0; d < 2; d++) begin
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, 11,              1'b1, 16'h0000);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, 2,               1'b1, 16'h0000);
            add(d, 1'b1, 5, 2'b11, 16'hA5C3, 1'b0, 0,               1'b0, 16'h0);
            add(d, 1'b1, 5, 2'b01, 16'h0011, 1'b0, 0,               1'b0, 16'h0);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, 5,               1'b1, 16'hA511);
            add(d, 1'b1, 7, 2'b11, 16'h1234, 1'b0, 0,               1'b0, 16'h0);
            add(d, 1'b1, 7, 2'b10, 16'hFFFF, 1'b1, 7,               1'b1, (d == 0) ? 16'h1234 : 16'hFF34);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, 7,               1'b1, 16'hFF34);
            add(d, 1'b1, 6, 2'b00, 16'h7777, 1'b0, 0,               1'b0, 16'h0);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, 6,               1'b1, 16'h0000);
            add(d, 1'b1, depth_of(d), 2'b11, 16'hBEEF, 1'b1, depth_of(d), 1'b1, 16'h0000);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, depth_of(d) - 1, 1'b1, 16'h0000);
            add(d, 1'b0, 0, 2'b00, 16'h0,    1'b1, depth_of(d) % 16, 1'b1, 16'h0000);
        end

        do_reset();
        sweep_both();

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            set_idle();
            if (v.dut == 0) req_a = v.req;
            else            req_b = v.req;
            step();
            set_idle();
            if (v.chk) begin
                for (int j = 1; j < lat_of(v.dut); j++) begin
                    check($sformatf("tbl%0d_early_valid", k), obs_valid(v.dut), 1'b0);
                    step();
                end
                check($sformatf("tbl%0d_valid", k), obs_valid(v.dut), 1'b1);
                check($sformatf("tbl%0d_data", k),  obs_data(v.dut),  v.exp);
                step();
                check($sformatf("tbl%0d_pulse", k), obs_valid(v.dut), 1'b0);
                check($sformatf("tbl%0d_hold", k),  obs_data(v.dut),  v.exp);
            end
        end

        // Back-to-back reads on both ports: consecutive valid cycles.
        req_a = '{1'b0, 0, 2'b00, 16'h0, 1'b1, 5};
        req_b = '{1'b0, 0, 2'b00, 16'h0, 1'b1, 5};
        step();
        req_a.raddr = 7;
        req_b.raddr = 7;
        step();
        set_idle();
        check("b2b_a_second_valid", bus_a.rd_valid, 1'b1);
        check("b2b_a_second_data",  bus_a.rd_data,  16'hFF34);
        step();
        check("b2b_b_second_valid", bus_b.rd_valid, 1'b1);
        step();

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 800; i++) begin
            req_a = rand_req(0);
            req_b = rand_req(1);
            step();
        end
        set_idle();
        step();
        step();

`ifdef RAM_PARITY_EN
        req_a = '{1'b1, 9, 2'b11, 16'h5A5A, 1'b0, 0};
        req_b = '{1'b1, 9, 2'b11, 16'h5A5A, 1'b0, 0};
        step();
        set_idle();
        dut_a.mem[9][0] = ~dut_a.mem[9][0];
        dut_b.mem[9][0] = ~dut_b.mem[9][0];
        mdl_mem[0][9][0] = ~mdl_mem[0][9][0];
        mdl_mem[1][9][0] = ~mdl_mem[1][9][0];
        corrupt[0][9] = 1'b1;
        corrupt[1][9] = 1'b1;
        req_a.re = 1'b1; req_a.raddr = 9;
        req_b.re = 1'b1; req_b.raddr = 9;
        step();
        set_idle();
        check("par_a_bad_valid", bus_a.rd_valid, 1'b1);
        check("par_a_bad_err",   bus_a.par_err,  1'b1);
        req_a.re = 1'b1; req_a.raddr = 5;
        req_b.re = 1'b1; req_b.raddr = 5;
        step();
        set_idle();
        check("par_b_bad_valid", bus_b.rd_valid, 1'b1);
        check("par_b_bad_err",   bus_b.par_err,  1'b1);
        check("par_a_good_err",  bus_a.par_err,  1'b0);
        step();
        check("par_b_good_err",  bus_b.par_err,  1'b0);
        step();
`endif

        // Reset pulsed 100 cycles into the sweep restarts it in full.
        do_reset();
        for (int i = 0; i < 100; i++) step();
        do_reset();
        sweep_both();
        req_a = '{1'b0, 0, 2'b00, 16'h0, 1'b1, 5};
        step();
        set_idle();
        check("post_reset_clear_valid", bus_a.rd_valid, 1'b1);
        check("post_reset_clear_data",  bus_a.rd_data,  16'h0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, one clock.
- Adds per-byte write enables, selectable read latency (1 or 2), a defined read-during-write policy, a read-valid strobe, and a post-reset clear sweep with a BUSY flag.
- Generic on-chip buffer for datapath blocks; replaces the fixed 16-bit x 3072 single-port RAM.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one write-enable lane.
- DEPTH, 3072, number of words; need not be a power of two.
- ADDR_WIDTH, 12, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- RD_LATENCY, 1, cycles from accepted read to data; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write collision policy: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no sweep.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- WR_EN  in  1  write request.
- WR_ADDR  in  ADDR_WIDTH  write address.
- WR_BE  in  DATA_WIDTH/BYTE_WIDTH  byte write enables; bit i selects lane i.
- WR_DATA  in  DATA_WIDTH  write data.
- RD_EN  in  1  read request.
- RD_ADDR  in  ADDR_WIDTH  read address.
- RD_DATA  out  DATA_WIDTH  read data.
- RD_VALID  out  1  one-cycle pulse per accepted read.
- BUSY  out  1  clear sweep in progress; all requests ignored while high.
- PAR_ERR  out  1  parity error, aligned with RD_VALID.

Behaviour:
- Definitions: NBYTES = DATA_WIDTH/BYTE_WIDTH. Lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- Reset values (asynchronous):
  - RD_DATA = 0, RD_VALID = 0, PAR_ERR = 0.
  - Read pipeline registers cleared.
  - BUSY = CLEAR_ON_RESET.
  - Array contents are not reset asynchronously.
- Init FSM states CLEAR and IDLE:
  - Reset forces CLEAR when CLEAR_ON_RESET = 1, otherwise IDLE.
  - In CLEAR, a counter runs 0..DEPTH-1 and writes one all-zero word per cycle, parity included.
  - CLEAR lasts exactly DEPTH cycles after RST deasserts. BUSY drops on the cycle after address DEPTH-1 is written; the FSM then enters IDLE and stays there.
  - RST asserted mid-sweep restarts the sweep from address 0.
- Requests:
  - While BUSY, WR_EN and RD_EN are ignored: no writes, no RD_VALID.
  - In IDLE, a read and a write may both be accepted in the same cycle. Throughput is one read plus one write per cycle.
- Write: on an edge with WR_EN = 1 and WR_ADDR < DEPTH, lane i is updated only where WR_BE[i] = 1. WR_BE = 0 performs no write.
- Read:
  - A read accepted at edge N gives RD_DATA and RD_VALID = 1 after edge N+RD_LATENCY.
  - RD_VALID is high for exactly one cycle per accepted read. Back-to-back reads give consecutive valid cycles.
  - RD_DATA holds its last value when RD_VALID = 0.
- Out-of-range addresses (>= DEPTH):
  - A write is dropped.
  - A read still produces RD_VALID, with RD_DATA = 0 and PAR_ERR = 0.
- Collision (both enables high, RD_ADDR == WR_ADDR, in range):
  - RDW_MODE 0: return the pre-write word.
  - RDW_MODE 1: return the merged word, i.e. WR_DATA in lanes with WR_BE set and old data elsewhere.
  - The array is updated identically in both modes.
- RD_LATENCY = 2 adds one output register stage. Collision results are decided at the array stage, not re-evaluated in the extra stage.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, written per lane under WR_BE.
  - On read, parity is recomputed per lane. PAR_ERR = OR of lane mismatches, registered with the same latency as RD_DATA.
  - In RDW_MODE 1, the parity of the merged word is recomputed.
- Undefined: no parity storage; PAR_ERR tied to 0. The port is always present.

Decomposition:
- Package ram_pkg:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1.
  - Function for even parity of a BYTE_WIDTH slice.
  - Function for byte-enable merge of old/new words.
  - Init-state enum (CLEAR, IDLE).
- Sub-module ram_init_seq: init FSM, clear counter, BUSY. It outputs the clear address and clear strobe to the top, which muxes them onto the write port.

Test Plan:
- Reset then idle, defaults (CLEAR_ON_RESET = 1, DEPTH = 3072) -> BUSY high exactly 3072 cycles after RST falls; a read of any address after that returns 0x0000.
- Reads during BUSY -> no RD_VALID; a write of 0xBEEF during BUSY -> the address still reads 0.
- Write 0xA5C3 with BE = 11 to addr 5, then 0x0011 with BE = 01 -> addr 5 reads 0xA511.
  - RD_LATENCY = 1: RD_VALID exactly 1 cycle after RD_EN.
  - RD_LATENCY = 2: RD_VALID exactly 2 cycles after RD_EN.
- Addr 7 holds 0x1234; same-cycle write 0xFFFF with BE = 10 and read of addr 7:
  - RDW_MODE 0 returns 0x1234.
  - RDW_MODE 1 returns 0xFF34.
  - A later read returns 0xFF34 in both modes.
- Read and write addr 3072 -> RD_VALID with data 0; array unchanged.
- RST pulsed at sweep cycle 100 -> BUSY stays high a full 3072 cycles after release.
- With RAM_PARITY_EN, force one flipped stored bit at addr 9 -> PAR_ERR = 1 coincident with RD_VALID.
  - Unforced reads: PAR_ERR = 0.
